// File: rtl/mtr_drv_if.sv
// Speed command / gate drive bundle between the balance controller and the motor driver.
interface mtr_drv_if;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               lft_ovr_i;
    logic               rght_ovr_i;
    logic               lft_hi;
    logic               lft_lo;
    logic               rght_hi;
    logic               rght_lo;
    logic               fault;

    modport master (
        output lft_spd, rght_spd, lft_ovr_i, rght_ovr_i,
        input  lft_hi, lft_lo, rght_hi, rght_lo, fault
    );
    modport slave (
        input  lft_spd, rght_spd, lft_ovr_i, rght_ovr_i,
        output lft_hi, lft_lo, rght_hi, rght_lo, fault
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM gate driver: shared counter, per-motor duty shadow, dead time,
// blanked over-current qualification feeding one sticky fault.
module mtr_drv_lane #(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 64,
    parameter int OVR_LIMIT  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        cnt,
    input  logic signed [11:0] spd,
    input  logic               ovr_i,
    input  logic               fault,
    output logic               hi,
    output logic               lo,
    output logic               trip
);
    localparam int DTW = $clog2(NONOVERLAP + 1);
    localparam int TW  = $clog2(BLANK + 1);
    localparam int CW  = $clog2(OVR_LIMIT + 1);

    logic signed [11:0] sat;
    logic [10:0]        duty, duty_sh;
    logic               pwm, pwm_nxt, wrap, hit, hit_now;
    logic [DTW-1:0]     dt;
    logic [TW-1:0]      on_tmr;
    logic [CW-1:0]      ovr_cnt;

    always_comb begin
        if (spd > 12'sd1023)       sat = 12'sd1023;
        else if (spd < -12'sd1024) sat = -12'sd1024;
        else                       sat = spd;
        duty = sat[10:0] + 11'h400;
    end

    assign wrap    = (cnt == 11'h7FF);
    assign pwm_nxt = (cnt < duty_sh);
    assign hit_now = ovr_i & hi & (on_tmr >= TW'(BLANK));
    // Fires on the period boundary that brings ovr_cnt up to the limit.
    assign trip    = wrap & (hit | hit_now) & (ovr_cnt == CW'(OVR_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_sh <= 11'h400;
            pwm     <= 1'b0;
            dt      <= DTW'(NONOVERLAP);
            hi      <= 1'b0;
            lo      <= 1'b0;
            on_tmr  <= '0;
            hit     <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            if (wrap) duty_sh <= duty;
            pwm <= pwm_nxt;
            // Reload together with the pwm edge so the gates never see a stale dt==0.
            if (pwm_nxt != pwm)  dt <= DTW'(NONOVERLAP);
            else if (dt != '0)   dt <= dt - 1'b1;
            hi <= pwm  & (dt == '0) & ~fault;
            lo <= ~pwm & (dt == '0) & ~fault;
            if (!hi)            on_tmr <= '0;
            else if (!(&on_tmr)) on_tmr <= on_tmr + 1'b1;
            if (wrap) begin
                hit <= 1'b0;
                if (!(hit | hit_now))              ovr_cnt <= '0;
                else if (ovr_cnt != CW'(OVR_LIMIT)) ovr_cnt <= ovr_cnt + 1'b1;
            end else begin
                hit <= hit | hit_now;
            end
        end
    end
endmodule

module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 64,
    parameter int OVR_LIMIT  = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mtr_drv_if.slave bus
);
    localparam int NUM_LANES = 2;

    logic [10:0]                 cnt;
    logic                        fault_q;
    logic [NUM_LANES-1:0][11:0]  spd;
    logic [NUM_LANES-1:0]        ovr, hi, lo, trip;

    // Lane 0 is the left motor, lane 1 the right.
    assign spd = {bus.rght_spd, bus.lft_spd};
    assign ovr = {bus.rght_ovr_i, bus.lft_ovr_i};

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        mtr_drv_lane #(
            .NONOVERLAP(NONOVERLAP), .BLANK(BLANK), .OVR_LIMIT(OVR_LIMIT)
        ) u_lane (
            .clk(clk), .rst_n(rst_n), .cnt(cnt), .spd($signed(spd[gi])),
            .ovr_i(ovr[gi]), .fault(fault_q), .hi(hi[gi]), .lo(lo[gi]), .trip(trip[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            fault_q <= fault_q | (|trip);
        end
    end

    assign bus.lft_hi  = hi[0];
    assign bus.lft_lo  = lo[0];
    assign bus.rght_hi = hi[1];
    assign bus.rght_lo = lo[1];
    assign bus.fault   = fault_q;
endmodule
